mips_pipe_ctrl: RTL
===================

Name: mips_pipe_ctrl

Overview:
Next-generation ID-stage control unit for the pipelined MIPS core. It combines the main decoder, the load-use and branch hazard detector, and a multi-cycle multiply sequencer into one block. It drives the PC/IF-ID write enables and the IF flush. It owns the control half of the ID/EX pipeline register, so all EX-bound control is registered. ALUOp is widened, and JAL, ORi, SLTi and MULT are added.

Parameters:
REG_AW, 5, register-index width
ALUOP_W, 4, ALUOp width (must be >=4)
MUL_LAT, 4, multiply latency in cycles (>=1)

Ports:
clk  in  1  core clock
rst  in  1  asynchronous, active-low reset
Inst  in  32  instruction in ID
SelCtrl  in  1  0 forces a bubble into ID/EX
equal  in  1  ID register comparator (rs==rt)
ex_RegWrite  in  1  EX-stage instruction writes a register
ex_MemRead  in  1  EX-stage instruction is a load
ex_WriteReg  in  REG_AW  EX-stage destination
mem_MemRead  in  1  MEM-stage instruction is a load
mem_WriteReg  in  REG_AW  MEM-stage destination
PCWrite, IFIDWrite  out  1 each  combinational enables
IFflush  out  1  combinational, flush IF/ID
PCSrc  out  2  combinational: 00 PC+4, 01 branch target, 10 jump target
RegDst  out  2  registered: 00 rt, 01 rd, 10 $31
RegWrite, ALUSrc, MemRead, MemWrite, MemToReg, Link, MulStart  out  1 each  registered ID/EX control
ALUOp  out  ALUOP_W  registered
Busy  out  1  multiplier sequencer active
Illegal  out  1  sticky unknown-opcode flag

Behaviour:
- Reset (rst=0, asynchronous): every registered output is 0, the FSM is in RUN, cnt=0, Illegal=0.
- Decode table (opcode/funct, then bundle):
  - R add, sub, and, or, slt: RegDst=01, RegWrite=1, ALUOp 0000, 0001, 0010, 0011, 0100.
  - R mult (funct 011000): MulStart=1, ALUOp=0101, RegWrite=0.
  - lw: RegWrite, ALUSrc, MemRead, MemToReg.
  - sw: ALUSrc, MemWrite.
  - addi, andi, ori, slti: RegWrite, ALUSrc, with ALUOp 0000, 0010, 0011, 0100 respectively.
  - beq, bne, j: no register write.
  - jal: RegWrite=1, RegDst=10, Link=1.
  - Unknown opcode or funct: NOP bundle, Illegal set (sticky until reset).
- Hazard = load-use OR branch.
  - Load-use: ex_MemRead and ex_WriteReg!=0 and the destination matches rs, or matches rt when rt is a source (R-type, beq, bne, sw).
  - Branch: beq/bne in ID, and either (ex_RegWrite and ex_WriteReg!=0 matching rs/rt) or (mem_MemRead and mem_WriteReg!=0 matching rs/rt).
- ID/EX register update each cycle. A bubble (all-zero bundle) is written when any of these holds: SelCtrl=0, hazard, state MUL_BUSY. Otherwise the decoded bundle is written.
- Outputs in RUN:
  - hazard=1: PCWrite=0, IFIDWrite=0, PCSrc=00, IFflush=0. Branch/jump resolution is suppressed while hazard is asserted.
  - no hazard: PCWrite=1, IFIDWrite=1.
  - Branch resolves in ID: beq with equal=1, or bne with equal=0, gives PCSrc=01 and IFflush=1.
  - j and jal give PCSrc=10 and IFflush=1.
  - SelCtrl=0 suppresses branch/jump resolution.
- FSM states RUN, MUL_BUSY.
  - RUN to MUL_BUSY: mult issued with no hazard, SelCtrl=1, and MUL_LAT>1. Load cnt=MUL_LAT-2. The issue cycle itself advances normally.
  - MUL_BUSY: PCWrite=0, IFIDWrite=0, IFflush=0, PCSrc=00, Busy=1.
  - MUL_BUSY exit: when cnt==0, go to RUN next cycle; otherwise cnt decrements.
  - Total stall after issue is MUL_LAT-1 cycles. MUL_LAT=1 never leaves RUN.
- Busy is registered and equals (state==MUL_BUSY).
- Reset mid-MUL_BUSY returns to RUN with Busy=0 immediately.
- Latency: the decoded bundle is visible on the registered outputs one clock after Inst is presented with no stall.

Decomposition:
- Package mips_ctrl_pkg holds: opcode and funct constants, ALUOp encodings, RegDst/PCSrc encodings, the ctrl_bundle_t struct, and the state enum.
- One sub-module, mips_main_decoder: a purely combinational decode from Inst to ctrl_bundle_t plus an illegal flag.
- The top level holds the hazard logic, the FSM/counter and the ID/EX register.

Test Plan:
- Load-use: ex_MemRead=1, ex_WriteReg=2, Inst=0x00441820 (add $3,$2,$4).
  - Required: PCWrite=0 and IFIDWrite=0; the next edge gives an all-zero bundle.
  - Then drop ex_MemRead. Required next edge: RegWrite=1, RegDst=01, ALUOp=0000.
- Branch: Inst=0x10210003 (beq $1,$1), equal=1, no hazard. Required: PCSrc=01, IFflush=1.
  - Repeat with ex_RegWrite=1, ex_WriteReg=1. Required: PCSrc=00, IFflush=0, PCWrite=0.
- Jump/link: Inst=0x0C000010 (jal). Required: PCSrc=10, IFflush=1; next edge RegWrite=1, RegDst=10, Link=1.
- Multiply: MUL_LAT=4, Inst=0x00430018 (mult $2,$3). Required after the issue edge: MulStart=1.
  - Busy=1 and PCWrite=0 for exactly 3 cycles.
  - Then RUN, and the held instruction issues.
  - Repeat with MUL_LAT=1. Required: no stall.
- Reset in MUL_BUSY: assert rst=0 asynchronously on the second busy cycle. Required: Busy=0, all bundle outputs 0, PCWrite=1 for a legal Inst.
- Illegal/SelCtrl:
  - Inst opcode 111111. Required: NOP bundle, Illegal=1, which stays set through later legal instructions until reset.
  - SelCtrl=0 with lw. Required: zero bundle.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the ID-stage control slice: opcodes, functs, ALUOp,
// RegDst/PCSrc codes, the ID/EX control bundle and the sequencer states.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_MULT = 6'b011000;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_SLT = 4'b0100;
  localparam logic [3:0] ALU_MUL = 4'b0101;

  typedef enum logic [1:0] {
    RD_RT = 2'b00,
    RD_RD = 2'b01,
    RD_RA = 2'b10
  } regdst_e;

  typedef enum logic [1:0] {
    PC_SEQ = 2'b00,
    PC_BR  = 2'b01,
    PC_JMP = 2'b10
  } pcsrc_e;

  typedef struct packed {
    regdst_e    reg_dst;
    logic       reg_write;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       link;
    logic       mul_start;
    logic [3:0] alu_op;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t CTRL_NOP = '0;

  typedef enum logic {
    RUN      = 1'b0,
    MUL_BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/mips_main_decoder.sv
// Main decoder: purely combinational Inst -> control bundle, zero latency.
// Unknown opcode/funct yields the NOP bundle and raises illegal.
module mips_main_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [31:0]  Inst,
  output ctrl_bundle_t ctrl,
  output logic         illegal
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       unused_fields;

  assign opcode        = Inst[31:26];
  assign funct         = Inst[5:0];
  assign unused_fields = ^Inst[25:6];

  always_comb begin
    ctrl    = CTRL_NOP;
    illegal = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD: begin ctrl.reg_dst = RD_RD; ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_ADD; end
          FN_SUB: begin ctrl.reg_dst = RD_RD; ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_SUB; end
          FN_AND: begin ctrl.reg_dst = RD_RD; ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_AND; end
          FN_OR:  begin ctrl.reg_dst = RD_RD; ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_OR;  end
          FN_SLT: begin ctrl.reg_dst = RD_RD; ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_SLT; end
          FN_MULT: begin
            ctrl.mul_start = 1'b1;
            ctrl.alu_op    = ALU_MUL;
          end
          default: illegal = 1'b1;
        endcase
      end
      OP_LW: begin
        ctrl.reg_write  = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      OP_SW: begin
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      OP_ADDI: begin ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1; ctrl.alu_op = ALU_ADD; end
      OP_ANDI: begin ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1; ctrl.alu_op = ALU_AND; end
      OP_ORI:  begin ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1; ctrl.alu_op = ALU_OR;  end
      OP_SLTI: begin ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1; ctrl.alu_op = ALU_SLT; end
      OP_BEQ, OP_BNE, OP_J: ;
      OP_JAL: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = RD_RA;
        ctrl.link      = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_pipe_ctrl.sv
// ID-stage control: hazard detection, branch/jump resolution, multiply stall sequencer
// and the control half of ID/EX. EX-bound control is registered (1 cycle); PC/IF enables are combinational.
module mips_pipe_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int ALUOP_W = 4,
  parameter int MUL_LAT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        Inst,
  input  logic               SelCtrl,
  input  logic               equal,
  input  logic               ex_RegWrite,
  input  logic               ex_MemRead,
  input  logic [REG_AW-1:0]  ex_WriteReg,
  input  logic               mem_MemRead,
  input  logic [REG_AW-1:0]  mem_WriteReg,
  output logic               PCWrite,
  output logic               IFIDWrite,
  output logic               IFflush,
  output logic [1:0]         PCSrc,
  output logic [1:0]         RegDst,
  output logic               RegWrite,
  output logic               ALUSrc,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               MemToReg,
  output logic               Link,
  output logic               MulStart,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               Busy,
  output logic               Illegal
);

  localparam int CNT_W = (MUL_LAT > 2) ? $clog2(MUL_LAT - 1) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = (MUL_LAT > 1) ? CNT_W'(MUL_LAT - 2) : '0;

  ctrl_bundle_t     dec_ctrl;
  logic             dec_illegal;
  ctrl_bundle_t     idex_q;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  pcsrc_e           pc_src;

  logic [5:0]        opcode;
  logic [REG_AW-1:0] rs, rt;
  logic is_beq, is_bne, is_br, is_jmp, rt_src;
  logic ex_hit, mem_hit, load_use, br_haz, hazard, taken, bubble;

  mips_main_decoder u_dec (
    .Inst    (Inst),
    .ctrl    (dec_ctrl),
    .illegal (dec_illegal)
  );

  assign opcode = Inst[31:26];
  assign rs     = REG_AW'(Inst[25:21]);
  assign rt     = REG_AW'(Inst[20:16]);
  assign is_beq = (opcode == OP_BEQ);
  assign is_bne = (opcode == OP_BNE);
  assign is_br  = is_beq | is_bne;
  assign is_jmp = (opcode == OP_J) | (opcode == OP_JAL);
  // rt is a read operand only for R-type, branches and stores
  assign rt_src = (opcode == OP_RTYPE) | is_br | (opcode == OP_SW);

  assign ex_hit  = (ex_WriteReg != '0) &&
                   ((ex_WriteReg == rs) || (rt_src && (ex_WriteReg == rt)));
  assign mem_hit = (mem_WriteReg != '0) &&
                   ((mem_WriteReg == rs) || (rt_src && (mem_WriteReg == rt)));

  assign load_use = ex_MemRead & ex_hit;
  assign br_haz   = is_br & ((ex_RegWrite & ex_hit) | (mem_MemRead & mem_hit));
  assign hazard   = load_use | br_haz;
  assign taken    = (is_beq & equal) | (is_bne & ~equal);
  assign bubble   = ~SelCtrl | hazard | (state_q == MUL_BUSY);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    PCWrite   = 1'b0;
    IFIDWrite = 1'b0;
    IFflush   = 1'b0;
    pc_src    = PC_SEQ;
    case (state_q)
      RUN: begin
        PCWrite   = ~hazard;
        IFIDWrite = ~hazard;
        if (!hazard && SelCtrl) begin
          if (taken) begin
            pc_src  = PC_BR;
            IFflush = 1'b1;
          end else if (is_jmp) begin
            pc_src  = PC_JMP;
            IFflush = 1'b1;
          end
          // The issue cycle advances normally; the stall starts the cycle after
          if (dec_ctrl.mul_start && (MUL_LAT > 1)) begin
            state_d = MUL_BUSY;
            cnt_d   = CNT_INIT;
          end
        end
      end
      MUL_BUSY: begin
        if (cnt_q == '0) state_d = RUN;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
      idex_q  <= CTRL_NOP;
      Illegal <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idex_q  <= bubble ? CTRL_NOP : dec_ctrl;
      if (dec_illegal && SelCtrl && (state_q == RUN)) Illegal <= 1'b1;
    end
  end

  assign PCSrc    = pc_src;
  assign RegDst   = idex_q.reg_dst;
  assign RegWrite = idex_q.reg_write;
  assign ALUSrc   = idex_q.alu_src;
  assign MemRead  = idex_q.mem_read;
  assign MemWrite = idex_q.mem_write;
  assign MemToReg = idex_q.mem_to_reg;
  assign Link     = idex_q.link;
  assign MulStart = idex_q.mul_start;
  assign ALUOp    = ALUOP_W'(idex_q.alu_op);
  assign Busy     = (state_q == MUL_BUSY);

endmodule
